mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
Multi-cycle memory-access sequencer between the processor control FSM and the external memory bus.
- Takes one fetch, load or store request at a time.
- Latches address and store data, drives the read/write strobe until the memory acknowledges, then returns read data with a one-cycle done pulse.
- Stalls the control FSM via oBusy.
- Flags bus timeouts and misaligned accesses as errors.

Parameters:
TIMEOUT_CYCLES, 16, max cycles the strobe is held waiting for iMemRdy before the error path (legal range 1..255).
ADDR_W, 32, address width.

Ports:
iClk  in  1  clock; single clock domain.
iRst  in  1  reset, synchronous, active-high.
iReq  in  1  start an access; sampled only in IDLE.
iWrite  in  1  1 = store, 0 = read; sampled with iReq.
iFetch  in  1  read is an instruction fetch; sampled with iReq; ignored when iWrite=1.
iAddr  in  ADDR_W  byte address; sampled with iReq.
iWData  in  32  store data; sampled with iReq.
oBusy  out  1  high in every state except IDLE.
oDone  out  1  one-cycle pulse on successful completion.
oFetchDone  out  1  one-cycle pulse, coincident with oDone, fetch requests only.
oErr  out  1  one-cycle pulse on timeout or misalignment.
oErrCode  out  2  00 none, 01 timeout, 10 misaligned; held until the next accepted request.
oRData  out  32  read data; held until the next completed read.
oMemAddr  out  ADDR_W  bus address; registered.
oMemWData  out  32  bus store data; registered.
oMemRd  out  1  read strobe.
oMemWr  out  1  write strobe.
iMemRdy  in  1  memory acknowledge; 1-cycle or level.
iMemRData  in  32  memory read data; valid when iMemRdy=1.

Behaviour:
- Reset (iRst=1 at a clock edge):
  - State goes to IDLE.
  - All outputs 0: oMemAddr, oMemWData, oRData, oErrCode, strobes, pulses.
  - Counter cleared.
  - Reset mid-access aborts immediately: strobes drop on the same edge and no oDone/oErr is issued.
- States: IDLE, ACCESS, RESP, ERR.
- IDLE:
  - oBusy=0, strobes 0.
  - iReq=1 latches iWrite, iFetch, iAddr, iWData, clears oErrCode and counter, then goes to ACCESS.
  - If alignment checking is active and iAddr[1:0]!=0, go to ERR with code 10 instead; no strobe is ever raised.
- ACCESS:
  - oMemRd = ~write, oMemWr = write; oMemAddr/oMemWData come from the latched values and are stable for the whole state.
  - iMemRdy=1 at an edge: for a read, oRData <= iMemRData; go to RESP.
  - Otherwise the counter increments. When the counter == TIMEOUT_CYCLES-1 and iMemRdy=0, go to ERR with code 01.
  - iMemRdy and the timeout limit on the same edge: iMemRdy wins.
- RESP:
  - Strobes 0, oDone=1, oFetchDone=latched fetch & ~write; one cycle only.
  - Then IDLE. iReq in RESP is ignored; the requester must hold or re-assert it.
- ERR:
  - Strobes 0, oErr=1 for one cycle, then IDLE.
  - oRData is unchanged.
- Latency: iReq edge to oDone = 2 + N cycles, where N = number of cycles iMemRdy stays low in ACCESS. Minimum 2 (ack on the first ACCESS edge). Back-to-back request throughput is 3 cycles per access.
- iReq held high in IDLE across completion starts a new access the cycle after RESP/ERR.
- iMemRdy outside ACCESS is ignored.
- Counter is 8 bits and never wraps; the counter limit check is an equality compare.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: misaligned requests (iAddr[1:0]!=0) go from IDLE directly to ERR with oErrCode=10 and raise no bus strobe.
- Undefined: no check; iAddr is passed through unmodified, the low bits reach the bus, and code 10 is never produced.

Test Plan:
1. Reset, then read iAddr=0x100 with iMemRdy tied 1, iMemRData=0xDEADBEEF → oMemRd high exactly 1 cycle; oDone pulses 2 cycles after iReq; oRData=0xDEADBEEF; oFetchDone=0.
2. Fetch iFetch=1, iAddr=0x0, iMemRdy asserted after 3 wait cycles → oBusy high 5 cycles; oDone and oFetchDone pulse together; oMemAddr stable 0x0 throughout ACCESS.
3. Store iWrite=1, iAddr=0x200, iWData=0x12345678, iMemRdy never asserted → oMemWr high 16 cycles, then oErr pulse with oErrCode=01; no oDone; prior oRData unchanged.
4. With MEM_ALIGN_CHECK_EN defined, read at iAddr=0x102 → oErr pulse one cycle after the request, oErrCode=10, oMemRd never asserted. Without the macro, the same request completes normally with oMemAddr=0x102.
5. Assert iRst during ACCESS (wait state 2) → strobes 0 and all outputs 0 on the next edge, no oDone/oErr; a subsequent read completes normally.
6. iReq held high for 3 back-to-back reads with immediate ack → oDone pulses at 3-cycle spacing; iMemRdy arriving exactly on the timeout-limit cycle yields oDone, not oErr.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Multi-cycle memory access sequencer: one fetch/load/store at a time, bus timeout and error reporting.
// Optional alignment checking is compiled in with `define MEM_ALIGN_CHECK_EN.
//
// state    | meaning
// IDLE     | waiting for iReq; bus strobes low, oBusy low
// ACCESS   | strobe held on the bus until iMemRdy or timeout
// RESP     | one-cycle oDone (and oFetchDone for fetches)
// ERR      | one-cycle oErr; oErrCode says why
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq,
  input  logic              iWrite,
  input  logic              iFetch,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [31:0]       iWData,
  output logic              oBusy,
  output logic              oDone,
  output logic              oFetchDone,
  output logic              oErr,
  output logic [1:0]        oErrCode,
  output logic [31:0]       oRData,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWData,
  output logic              oMemRd,
  output logic              oMemWr,
  input  logic              iMemRdy,
  input  logic [31:0]       iMemRData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_ERR
  } state_t;

  localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
`ifdef MEM_ALIGN_CHECK_EN
  localparam logic [1:0] CODE_MISALIGN = 2'b10;
`endif

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic              fetch_q, fetch_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        err_code_q, err_code_d;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      fetch_q     <= 1'b0;
      cnt_q       <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_code_q  <= CODE_NONE;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      fetch_q     <= fetch_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_code_q  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    fetch_d     = fetch_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      S_IDLE: begin
        if (iReq) begin
          write_d     = iWrite;
          fetch_d     = iFetch;
          mem_addr_d  = iAddr;
          mem_wdata_d = iWData;
          err_code_d  = CODE_NONE;
          cnt_d       = 8'd0;
          state_d     = S_ACCESS;
`ifdef MEM_ALIGN_CHECK_EN
          if (iAddr[1:0] != 2'b00) begin
            err_code_d = CODE_MISALIGN;
            state_d    = S_ERR;
          end
`endif
        end
      end
      S_ACCESS: begin
        // an acknowledge on the limit cycle still counts as success
        if (iMemRdy) begin
          if (!write_q) rdata_d = iMemRData;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          err_code_d = CODE_TIMEOUT;
          state_d    = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign oBusy      = (state_q != S_IDLE);
  assign oMemRd     = (state_q == S_ACCESS) && !write_q;
  assign oMemWr     = (state_q == S_ACCESS) && write_q;
  assign oDone      = (state_q == S_RESP);
  assign oFetchDone = (state_q == S_RESP) && fetch_q && !write_q;
  assign oErr       = (state_q == S_ERR);
  assign oErrCode   = err_code_q;
  assign oRData     = rdata_q;
  assign oMemAddr   = mem_addr_q;
  assign oMemWData  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: per-transaction timeline model plus directed literal checks.
module tb_mem_access_ctrl;
  localparam int TMO = 16;

  logic        iClk = 1'b0;
  logic        iRst, iReq, iWrite, iFetch, iMemRdy;
  logic [31:0] iAddr, iWData, iMemRData;
  logic        oBusy, oDone, oFetchDone, oErr, oMemRd, oMemWr;
  logic [1:0]  oErrCode;
  logic [31:0] oRData, oMemAddr, oMemWData;

  always #5 iClk = ~iClk;

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO), .ADDR_W(32)) dut (
    .iClk(iClk), .iRst(iRst), .iReq(iReq), .iWrite(iWrite), .iFetch(iFetch),
    .iAddr(iAddr), .iWData(iWData), .oBusy(oBusy), .oDone(oDone),
    .oFetchDone(oFetchDone), .oErr(oErr), .oErrCode(oErrCode), .oRData(oRData),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemRd(oMemRd), .oMemWr(oMemWr),
    .iMemRdy(iMemRdy), .iMemRData(iMemRData)
  );

  // expected outputs for the current cycle, written by the driver
  logic        e_busy, e_done, e_fdone, e_err, e_rd, e_wr, e_chkbus;
  logic [1:0]  e_code;
  logic [31:0] e_rdata, e_addr, e_wdata;
  logic [31:0] m_rdata;
  logic [1:0]  m_code;
  logic        chk_en = 1'b0;

  int n_cmp = 0, n_err = 0, cyc = 0;
  int cnt_rd = 0, cnt_wr = 0, cnt_busy = 0, cnt_done = 0, cnt_fdone = 0, cnt_err = 0;
  int last_done_cyc = 0;
  logic [31:0] last_rd_addr = 32'd0;

  string       lit_name;
  logic [31:0] lit_act, lit_exp;
  int          lit_seq = 0, lit_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (chk_en) begin
      cyc++;
      chk("busy",  32'(oBusy),      32'(e_busy));
      chk("done",  32'(oDone),      32'(e_done));
      chk("fdone", 32'(oFetchDone), 32'(e_fdone));
      chk("err",   32'(oErr),       32'(e_err));
      chk("code",  32'(oErrCode),   32'(e_code));
      chk("rdata", oRData,          e_rdata);
      chk("memrd", 32'(oMemRd),     32'(e_rd));
      chk("memwr", 32'(oMemWr),     32'(e_wr));
      if (e_chkbus) begin
        chk("memaddr",  oMemAddr,  e_addr);
        chk("memwdata", oMemWData, e_wdata);
      end
      if (oMemRd) begin cnt_rd++; last_rd_addr = oMemAddr; end
      if (oMemWr) cnt_wr++;
      if (oBusy) cnt_busy++;
      if (oDone) begin cnt_done++; last_done_cyc = cyc; end
      if (oFetchDone) cnt_fdone++;
      if (oErr) cnt_err++;
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        chk(lit_name, lit_act, lit_exp);
      end
    end
  end

  function automatic logic rbit();
    return 1'($urandom & 32'd1);
  endfunction

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic set_exp(input logic busy, done, fdone, err, rd, wr, chkbus,
                         input logic [31:0] addr, wdata);
    e_busy = busy; e_done = done; e_fdone = fdone; e_err = err;
    e_rd = rd; e_wr = wr; e_chkbus = chkbus; e_addr = addr; e_wdata = wdata;
    e_code = m_code; e_rdata = m_rdata;
  endtask

  task automatic scramble();
    iReq = rbit(); iWrite = rbit(); iFetch = rbit();
    iAddr = $urandom; iWData = $urandom; iMemRData = $urandom; iMemRdy = rbit();
  endtask

  task automatic idle_cyc();
    set_exp(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    scramble();
    iReq = 1'b0;
    step();
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    lit_name = nm; lit_act = act; lit_exp = exp; lit_seq++;
    idle_cyc();
  endtask

  // One request from an IDLE cycle: memory acks after nwait low cycles (never if nwait >= TMO).
  task automatic do_txn(input logic w, input logic f, input logic [31:0] a,
                        input logic [31:0] wd, input int nwait, input logic [31:0] rd);
    logic mis;
    int   len;
    set_exp(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    scramble();
    iReq = 1'b1; iWrite = w; iFetch = f; iAddr = a; iWData = wd;
    step();
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    if (mis) begin
      m_code = 2'd2;
      set_exp(1, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
      scramble();
      step();
      return;
    end
    m_code = 2'd0;
    len = (nwait < TMO) ? nwait + 1 : TMO;
    for (int i = 0; i < len; i++) begin
      set_exp(1, 0, 0, 0, !w, w, 1, a, wd);
      scramble();
      iMemRdy = (i == nwait);
      if (i == nwait) iMemRData = rd;
      step();
    end
    if (nwait < TMO) begin
      if (!w) m_rdata = rd;
      set_exp(1, 1, f & !w, 0, 0, 0, 0, 32'd0, 32'd0);
    end else begin
      m_code = 2'd1;
      set_exp(1, 0, 0, 1, 0, 0, 0, 32'd0, 32'd0);
    end
    scramble();
    step();
  endtask

  int s_rd, s_wr, s_busy, s_done, s_fdone, s_err, req0;

  task automatic snap();
    s_rd = cnt_rd; s_wr = cnt_wr; s_busy = cnt_busy;
    s_done = cnt_done; s_fdone = cnt_fdone; s_err = cnt_err;
  endtask

  initial begin
    iRst = 1'b1; iReq = 1'b0; iWrite = 1'b0; iFetch = 1'b0; iAddr = 32'd0;
    iWData = 32'd0; iMemRdy = 1'b0; iMemRData = 32'd0;
    m_rdata = 32'd0; m_code = 2'd0;
    step();
    set_exp(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    chk_en = 1'b1;
    step();
    iRst = 1'b0;
    idle_cyc();

    // 1: plain read with immediate ack
    snap();
    req0 = cyc + 1;
    do_txn(1'b0, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    lit("t1_rd_cycles", 32'(cnt_rd - s_rd), 32'd1);
    lit("t1_done_latency", 32'(last_done_cyc - req0), 32'd2);
    lit("t1_rdata", oRData, 32'hDEADBEEF);
    lit("t1_fdone", 32'(cnt_fdone - s_fdone), 32'd0);

    // 2: fetch with three wait cycles
    snap();
    do_txn(1'b0, 1'b1, 32'h0, 32'h0, 3, 32'hCAFEF00D);
    lit("t2_busy_cycles", 32'(cnt_busy - s_busy), 32'd5);
    lit("t2_fdone", 32'(cnt_fdone - s_fdone), 32'd1);
    lit("t2_done", 32'(cnt_done - s_done), 32'd1);

    // 3: store that never gets an ack
    snap();
    do_txn(1'b1, 1'b0, 32'h200, 32'h12345678, TMO + 5, 32'h0);
    lit("t3_wr_cycles", 32'(cnt_wr - s_wr), 32'd16);
    lit("t3_err", 32'(cnt_err - s_err), 32'd1);
    lit("t3_done", 32'(cnt_done - s_done), 32'd0);
    lit("t3_code", 32'(oErrCode), 32'd1);
    lit("t3_rdata_kept", oRData, 32'hCAFEF00D);

    // 4: misaligned read
    snap();
    do_txn(1'b0, 1'b0, 32'h102, 32'h0, 0, 32'h55AA55AA);
`ifdef MEM_ALIGN_CHECK_EN
    lit("t4_err", 32'(cnt_err - s_err), 32'd1);
    lit("t4_rd_cycles", 32'(cnt_rd - s_rd), 32'd0);
    lit("t4_code", 32'(oErrCode), 32'd2);
`else
    lit("t4_done", 32'(cnt_done - s_done), 32'd1);
    lit("t4_bus_addr", last_rd_addr, 32'h102);
    lit("t4_code", 32'(oErrCode), 32'd0);
`endif

    // 5: reset in the third ACCESS cycle
    snap();
    set_exp(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0);
    scramble();
    iReq = 1'b1; iWrite = 1'b0; iFetch = 1'b0; iAddr = 32'h300; iWData = 32'h0;
    step();
    m_code = 2'd0;
    for (int i = 0; i < 3; i++) begin
      set_exp(1, 0, 0, 0, 1, 0, 1, 32'h300, 32'h0);
      scramble();
      iMemRdy = 1'b0;
      iWrite = 1'b0;
      if (i == 2) iRst = 1'b1;
      step();
    end
    m_rdata = 32'd0;
    m_code = 2'd0;
    set_exp(0, 0, 0, 0, 0, 0, 1, 32'd0, 32'd0);
    scramble();
    iRst = 1'b0;
    iReq = 1'b0;
    step();
    lit("t5_no_done", 32'(cnt_done - s_done), 32'd0);
    lit("t5_no_err", 32'(cnt_err - s_err), 32'd0);
    do_txn(1'b0, 1'b0, 32'h304, 32'h0, 1, 32'h0BADF00D);
    lit("t5_after_rdata", oRData, 32'h0BADF00D);

    // 6: back-to-back reads, then ack on the timeout-limit cycle
    snap();
    req0 = cyc + 1;
    do_txn(1'b0, 1'b0, 32'h400, 32'h0, 0, 32'h11111111);
    do_txn(1'b0, 1'b0, 32'h404, 32'h0, 0, 32'h22222222);
    do_txn(1'b0, 1'b0, 32'h408, 32'h0, 0, 32'h33333333);
    lit("t6_b2b_done", 32'(cnt_done - s_done), 32'd3);
    lit("t6_b2b_last", 32'(last_done_cyc - req0), 32'd8);
    snap();
    do_txn(1'b0, 1'b0, 32'h500, 32'h0, TMO - 1, 32'h44444444);
    lit("t6_limit_done", 32'(cnt_done - s_done), 32'd1);
    lit("t6_limit_err", 32'(cnt_err - s_err), 32'd0);
    lit("t6_limit_rd", 32'(cnt_rd - s_rd), 32'd16);

    // randomized traffic
    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      int nw;
      int gap;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      nw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4))
                                      : int'($urandom_range(TMO - 2, TMO + 2));
      do_txn(rbit(), rbit(), a, $urandom, nw, $urandom);
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) idle_cyc();
    end

    idle_cyc();
    idle_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
